adc_cfg_seq: RTL

- Parametrised successor to the AD9252 bring-up sequencer.
- Issues a TEST table of SPI words, waits for the deserializer to report alignment, then issues a WORK table, with a handshake to the SPI master between words.
- Adds per-word busy handshake, configurable table lengths, alignment timeout with retry, an error state and software restart.
- Sits between the SPI master and the LVDS alignment logic in the ADC front end.

---
 rtl/adc_cfg_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/adc_cfg_seq.sv
// rtl/adc_cfg_seq.sv - ADC SPI configuration sequencer: TEST table, wait for LVDS alignment, WORK table
// Optional feature macro: ADC_CFG_ALIGN_TIMEOUT_EN (alignment timeout, retry and ERROR state)
module adc_cfg_seq #(
  parameter int                         DATA_W     = 32,
  parameter int                         N_TEST     = 2,
  parameter int                         N_WORK     = 2,
  parameter logic [N_TEST*DATA_W-1:0]   TEST_WORDS = {32'h00FF0101, 32'h000D0C0C},
  parameter logic [N_WORK*DATA_W-1:0]   WORK_WORDS = {32'h00FF0101, 32'h000D0000},
  parameter int                         DELAY_CYC  = 1024,
  parameter int                         ALIGN_TO   = 1048576,
  parameter int                         MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              spi_busy,
  input  logic              data_aligned,
  output logic [DATA_W-1:0] adc_data,
  output logic              start,
  output logic              test_cfg_done,
  output logic              spi_done,
  output logic              cfg_error,
  output logic [3:0]        state,
  output logic [2:0]        word_idx
);

  localparam int              DLY_W    = $clog2(DELAY_CYC + 1);
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(DELAY_CYC);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam logic [2:0]      LAST_T   = 3'(N_TEST - 1);
  localparam logic [2:0]      LAST_W   = 3'(N_WORK - 1);

  // Table sizes are limited by the 3-bit word index; catch bad overrides at elaboration.
  if (N_TEST < 1 || N_TEST > 8 || N_WORK < 1 || N_WORK > 8 ||
      DELAY_CYC < 1 || ALIGN_TO < 1 || MAX_RETRY < 0) begin : g_bad_params
    $error("adc_cfg_seq: parameter out of range");
  end

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_PWR_DLY    = 4'd1,
    S_LOAD       = 4'd2,
    S_START      = 4'd3,
    S_WAIT_ACK   = 4'd4,
    S_WAIT_DONE  = 4'd5,
    S_GAP_DLY    = 4'd6,
    S_ALIGN_WAIT = 4'd7,
    S_DONE       = 4'd8,
    S_ERROR      = 4'd9
  } state_t;

  state_t           st;
  logic             phase;      // 0 = TEST table, 1 = WORK table
  logic [2:0]       idx;
  logic [DLY_W-1:0] dly_cnt;
  logic [2:0]       last_idx;

  assign state    = st;
  assign word_idx = idx;
  assign last_idx = phase ? LAST_W : LAST_T;

`ifdef ADC_CFG_ALIGN_TIMEOUT_EN
  localparam int               TO_W    = $clog2(ALIGN_TO + 1);
  localparam int               RT_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ALIGN_TO - 1);
  localparam logic [RT_W-1:0]  RT_MAX  = RT_W'(MAX_RETRY);

  logic [TO_W-1:0] to_cnt;
  logic [RT_W-1:0] retry;
  logic            cfg_error_q;

  assign cfg_error = cfg_error_q;
`else
  assign cfg_error = 1'b0;
`endif

  // Sequencer FSM; restart behaves like reset so it wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      st            <= S_IDLE;
      phase         <= 1'b0;
      idx           <= 3'd0;
      dly_cnt       <= DLY_INIT;
      adc_data      <= '0;
      start         <= 1'b0;
      test_cfg_done <= 1'b0;
      spi_done      <= 1'b0;
`ifdef ADC_CFG_ALIGN_TIMEOUT_EN
      to_cnt        <= '0;
      retry         <= '0;
      cfg_error_q   <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      case (st)
        // An abandoned transfer may still be running; hold off until the master is idle.
        S_IDLE: begin
          if (!spi_busy) begin
            st      <= S_PWR_DLY;
            dly_cnt <= DLY_INIT;
          end
        end
        S_PWR_DLY: begin
          if (dly_cnt <= DLY_ONE) begin
            st    <= S_LOAD;
            idx   <= 3'd0;
            phase <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - DLY_ONE;
          end
        end
        S_LOAD: begin
          adc_data <= phase ? WORK_WORDS[idx*DATA_W +: DATA_W]
                            : TEST_WORDS[idx*DATA_W +: DATA_W];
          start    <= 1'b1;
          st       <= S_START;
        end
        // Always pass through WAIT_ACK, even if the master already shows busy.
        S_START: st <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (spi_busy) st <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!spi_busy) begin
            st      <= S_GAP_DLY;
            dly_cnt <= DLY_INIT;
          end
        end
        S_GAP_DLY: begin
          if (dly_cnt <= DLY_ONE) begin
            if (idx < last_idx) begin
              idx <= idx + 3'd1;
              st  <= S_LOAD;
            end else if (!phase) begin
              st            <= S_ALIGN_WAIT;
              test_cfg_done <= 1'b1;
`ifdef ADC_CFG_ALIGN_TIMEOUT_EN
              to_cnt        <= '0;
`endif
            end else begin
              st       <= S_DONE;
              spi_done <= 1'b1;
            end
          end else begin
            dly_cnt <= dly_cnt - DLY_ONE;
          end
        end
        S_ALIGN_WAIT: begin
          if (data_aligned) begin
            phase <= 1'b1;
            idx   <= 3'd0;
            st    <= S_LOAD;
          end
`ifdef ADC_CFG_ALIGN_TIMEOUT_EN
          else if (to_cnt >= TO_LAST) begin
            if (retry < RT_MAX) begin
              retry         <= retry + RT_W'(1);
              test_cfg_done <= 1'b0;
              phase         <= 1'b0;
              idx           <= 3'd0;
              st            <= S_LOAD;
            end else begin
              st          <= S_ERROR;
              cfg_error_q <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        S_DONE:  st <= S_DONE;
        S_ERROR: st <= S_ERROR;
        default: begin
          st            <= S_IDLE;
          test_cfg_done <= 1'b0;
          spi_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
